cpu_clk_ctrl: RTL and testbench

- Run/step/break controller for the single-cycle CPU clock, sitting between the board switches/buttons and the CPU core.
- Produces a glitch-free divided clock `Clk_CPU` and an aligned one-cycle enable `cpu_en` in the `clk` domain.
- Supports continuous fast or slow run, debounced single-step, and a CPU-requested break.
- Keeps a 16-bit count of issued CPU cycles.

---
 rtl/cpu_clk_ctrl.sv | 208 ++++++++++++++++++++
 tb/tb_cpu_clk_ctrl.sv | 254 +++++++++++++++++++++++++
 2 files changed

// File: rtl/cpu_clk_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : cpu_clk_ctrl
// Description : Run / step / break controller for the single-cycle CPU clock.
//               Generates a registered, glitch-free divided clock Clk_CPU and
//               an aligned one-cycle enable cpu_en in the clk domain. Supports
//               continuous fast or slow run, a debounced single step and a
//               CPU-requested break, and counts issued CPU cycles.
//
// Ports       : clk       in   system clock, all flops on its rising edge
//               rst       in   asynchronous active-high reset
//               run       in   1 = continuous run, 0 = halt / step mode
//               slow      in   1 = slow period, 0 = fast period
//               step_btn  in   raw asynchronous step push-button
//               brk       in   break request from the CPU (level)
//               Clk_CPU   out  divided CPU clock (registered)
//               cpu_en    out  one-cycle pulse per CPU cycle (registered)
//               state     out  00 HALT, 01 RUN, 10 STEP, 11 BREAK
//               cyc_cnt   out  16-bit count of cpu_en pulses, wraps
//
// Revision    : 1.0  initial release
// ============================================================================
module cpu_clk_ctrl #(
    parameter int FAST_LOG2 = 3,
    parameter int SLOW_LOG2 = 26,
    parameter int DB_CYCLES = 1000000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        run,
    input  logic        slow,
    input  logic        step_btn,
    input  logic        brk,
    output logic        Clk_CPU,
    output logic        cpu_en,
    output logic [1:0]  state,
    output logic [15:0] cyc_cnt
);

    localparam int DB_W = $clog2(DB_CYCLES);

    localparam logic [DB_W-1:0]      C_DB_LAST   = DB_W'(DB_CYCLES - 1);
    localparam logic [SLOW_LOG2-1:0] C_FAST_LAST = SLOW_LOG2'((1 << FAST_LOG2) - 1);
    localparam logic [SLOW_LOG2-1:0] C_SLOW_LAST = '1;
    localparam logic [SLOW_LOG2-1:0] C_CNT_ONE   = SLOW_LOG2'(1);
    localparam logic [DB_W-1:0]      C_DB_ONE    = DB_W'(1);

    typedef enum logic [1:0] {
        S_HALT  = 2'b00,
        S_RUN   = 2'b01,
        S_STEP  = 2'b10,
        S_BREAK = 2'b11
    } state_t;

    state_t                 r_state;
    state_t                 w_state_nxt;
    logic [SLOW_LOG2-1:0]   r_cnt;
    logic                   r_slow_q;
    logic                   r_brk_l;
    logic                   r_clk_cpu;
    logic                   r_cpu_en;
    logic [15:0]            r_cyc_cnt;

    logic                   r_sync1;
    logic                   r_sync2;
    logic                   r_db_level;
    logic [DB_W-1:0]        r_db_cnt;
    logic                   r_step_evt;

    logic                   w_active;
    logic                   w_use_slow;
    logic                   w_cnt_last;
    logic                   w_first_half;

    // ------------------------------------------------------------------------
    // Period / phase decode. A step always runs at the fast rate, so the slow
    // selection only matters while in RUN.
    // ------------------------------------------------------------------------
    assign w_active     = (r_state == S_RUN) || (r_state == S_STEP);
    assign w_use_slow   = r_slow_q && (r_state == S_RUN);
    assign w_cnt_last   = w_use_slow ? (r_cnt == C_SLOW_LAST) : (r_cnt == C_FAST_LAST);
    // cnt never exceeds the active period, so the top bit of the active
    // width alone tells the first half from the second.
    assign w_first_half = w_use_slow ? ~r_cnt[SLOW_LOG2-1] : ~r_cnt[FAST_LOG2-1];

    // ------------------------------------------------------------------------
    // Step button: 2-FF synchronizer, stability debounce, rising-edge event.
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sync1    <= 1'b0;
            r_sync2    <= 1'b0;
            r_db_level <= 1'b0;
            r_db_cnt   <= '0;
            r_step_evt <= 1'b0;
        end else begin
            r_sync1    <= step_btn;
            r_sync2    <= r_sync1;
            r_step_evt <= 1'b0;
            if (r_sync2 != r_db_level) begin
                if (r_db_cnt == C_DB_LAST) begin
                    r_db_level <= r_sync2;
                    r_db_cnt   <= '0;
                    r_step_evt <= r_sync2;
                end else begin
                    r_db_cnt <= r_db_cnt + C_DB_ONE;
                end
            end else begin
                r_db_cnt <= '0;
            end
        end
    end

    // ------------------------------------------------------------------------
    // Next-state logic. RUN only leaves at a period boundary so the CPU clock
    // never gets a truncated pulse.
    // ------------------------------------------------------------------------
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_HALT: begin
                if (run && !brk) begin
                    w_state_nxt = S_RUN;
                end else if (!run && r_step_evt) begin
                    w_state_nxt = S_STEP;
                end
            end
            S_RUN: begin
                if (w_cnt_last) begin
                    if (r_brk_l) begin
                        w_state_nxt = S_BREAK;
                    end else if (!run) begin
                        w_state_nxt = S_HALT;
                    end
                end
            end
            S_STEP: begin
                if (w_cnt_last) begin
                    w_state_nxt = S_HALT;
                end
            end
            S_BREAK: begin
                if (!run) begin
                    w_state_nxt = S_HALT;
                end
            end
            default: w_state_nxt = S_HALT;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_HALT;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // ------------------------------------------------------------------------
    // Phase counter, rate latch and break latch.
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt    <= '0;
            r_slow_q <= 1'b0;
            r_brk_l  <= 1'b0;
        end else begin
            if (w_active && !w_cnt_last) begin
                r_cnt <= r_cnt + C_CNT_ONE;
            end else begin
                r_cnt <= '0;
            end

            // Rate only changes between periods, never mid-period.
            if (!w_active || w_cnt_last) begin
                r_slow_q <= slow;
            end

            if ((r_state == S_BREAK) && (w_state_nxt == S_HALT)) begin
                r_brk_l <= 1'b0;
            end else if ((r_state == S_RUN) && brk) begin
                r_brk_l <= 1'b1;
            end
        end
    end

    // ------------------------------------------------------------------------
    // Registered outputs, one cycle behind (state, cnt).
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_clk_cpu <= 1'b0;
            r_cpu_en  <= 1'b0;
            r_cyc_cnt <= '0;
        end else begin
            r_clk_cpu <= w_active && w_first_half;
            r_cpu_en  <= w_active && (r_cnt == '0);
            r_cyc_cnt <= r_cyc_cnt + {15'd0, r_cpu_en};
        end
    end

    assign Clk_CPU = r_clk_cpu;
    assign cpu_en  = r_cpu_en;
    assign state   = r_state;
    assign cyc_cnt = r_cyc_cnt;

endmodule
`default_nettype wire

// File: tb/tb_cpu_clk_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_cpu_clk_ctrl
// Description : Self-checking bench for cpu_clk_ctrl. Expected per-cycle
//               outputs are queued when stimulus is applied and compared as
//               the DUT produces them; debounced step windows are checked by
//               pulse counting.
// Revision    : 1.0  initial release
// ============================================================================
module tb_cpu_clk_ctrl;

    localparam int FAST_LOG2 = 2;
    localparam int SLOW_LOG2 = 4;
    localparam int DB_CYCLES = 4;

    localparam logic [1:0] ST_HALT  = 2'b00;
    localparam logic [1:0] ST_RUN   = 2'b01;
    localparam logic [1:0] ST_STEP  = 2'b10;
    localparam logic [1:0] ST_BREAK = 2'b11;

    logic        clk = 1'b0;
    logic        rst;
    logic        run;
    logic        slow;
    logic        step_btn;
    logic        brk;
    logic        Clk_CPU;
    logic        cpu_en;
    logic [1:0]  state;
    logic [15:0] cyc_cnt;

    cpu_clk_ctrl #(
        .FAST_LOG2 (FAST_LOG2),
        .SLOW_LOG2 (SLOW_LOG2),
        .DB_CYCLES (DB_CYCLES)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .run      (run),
        .slow     (slow),
        .step_btn (step_btn),
        .brk      (brk),
        .Clk_CPU  (Clk_CPU),
        .cpu_en   (cpu_en),
        .state    (state),
        .cyc_cnt  (cyc_cnt)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic        clk_cpu;
        logic        en;
        logic [1:0]  st;
        logic [15:0] cyc;
    } exp_t;

    exp_t        sb_q[$];
    int          n_vec   = 0;
    int          n_err   = 0;
    logic [15:0] exp_cyc = 16'd0;
    string       phase   = "init";
    int          win_en;
    int          win_clk;
    logic        win_step;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s/%s: got %0h expected %0h at %0t", phase, tag, obs, exp, $time);
        end
    endtask

    // One expected output cycle; cyc_cnt lags cpu_en by a cycle.
    task automatic push_e(input logic c, input logic e, input logic [1:0] s);
        exp_t item;
        item.clk_cpu = c;
        item.en      = e;
        item.st      = s;
        item.cyc     = exp_cyc;
        sb_q.push_back(item);
        if (e) exp_cyc = exp_cyc + 16'd1;
    endtask

    // One full CPU period of length p; the last cycle carries the state
    // the controller moves to at the period boundary.
    task automatic push_period(input int p, input logic [1:0] s, input logic [1:0] last_s);
        for (int i = 0; i < p; i++) begin
            push_e(i < p / 2, i == 0, (i == p - 1) ? last_s : s);
        end
    endtask

    task automatic run_cycles(input int n);
        exp_t e;
        repeat (n) begin
            @(posedge clk);
            #1;
            if (sb_q.size() == 0) begin
                check("sb_underflow", 32'(sb_q.size()), 32'd1);
            end else begin
                e = sb_q.pop_front();
                check("clk_cpu", {31'd0, Clk_CPU}, {31'd0, e.clk_cpu});
                check("cpu_en",  {31'd0, cpu_en},  {31'd0, e.en});
                check("state",   {30'd0, state},   {30'd0, e.st});
                check("cyc_cnt", {16'd0, cyc_cnt}, {16'd0, e.cyc});
            end
        end
    endtask

    // Cycles whose exact timing depends on debounce latency: observe only.
    task automatic run_window(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
            win_en  += int'(cpu_en);
            win_clk += int'(Clk_CPU);
            if (state == ST_STEP) win_step = 1'b1;
        end
    endtask

    task automatic clear_window();
        win_en   = 0;
        win_clk  = 0;
        win_step = 1'b0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst = 1'b1; run = 1'b0; slow = 1'b0; step_btn = 1'b0; brk = 1'b0;

        // Reset and idle HALT
        phase = "reset";
        repeat (3) push_e(1'b0, 1'b0, ST_HALT);
        run_cycles(3);
        rst = 1'b0;
        phase = "idle";
        repeat (20) push_e(1'b0, 1'b0, ST_HALT);
        run_cycles(20);

        // Fast run: five periods
        phase = "fast_run";
        run = 1'b1;
        push_e(1'b0, 1'b0, ST_RUN);
        repeat (5) push_period(4, ST_RUN, ST_RUN);
        run_cycles(21);
        check("cyc_after_5", {16'd0, cyc_cnt}, 32'd5);

        // Slow request mid-period: current fast period completes first
        phase = "to_slow";
        push_period(4, ST_RUN, ST_RUN);
        run_cycles(1);
        slow = 1'b1;
        run_cycles(3);
        repeat (2) push_period(16, ST_RUN, ST_RUN);
        run_cycles(32);

        // Stop at the end of the current slow period
        phase = "stop";
        run  = 1'b0;
        slow = 1'b0;
        push_period(16, ST_RUN, ST_HALT);
        repeat (3) push_e(1'b0, 1'b0, ST_HALT);
        run_cycles(19);

        // Short press is rejected
        phase = "short_press";
        clear_window();
        step_btn = 1'b1;
        run_window(3);
        step_btn = 1'b0;
        run_window(12);
        check("short_en",   32'(win_en), 32'd0);
        check("short_step", {31'd0, win_step}, 32'd0);

        // Long press yields exactly one step, holding does not repeat it
        phase = "long_press";
        clear_window();
        step_btn = 1'b1;
        run_window(10);
        run_window(50);
        check("step_en_count",  32'(win_en), 32'd1);
        check("step_clk_high",  32'(win_clk), 32'd2);
        check("step_seen",      {31'd0, win_step}, 32'd1);
        check("step_end_state", {30'd0, state}, {30'd0, ST_HALT});
        check("step_cyc",       {16'd0, cyc_cnt}, {16'd0, exp_cyc + 16'd1});
        exp_cyc = exp_cyc + 16'd1;
        clear_window();
        step_btn = 1'b0;
        run_window(15);
        check("release_en", 32'(win_en), 32'd0);

        // Break: one-cycle brk at cnt==1 finishes the period, then BREAK
        phase = "break";
        run = 1'b1;
        push_e(1'b0, 1'b0, ST_RUN);
        push_period(4, ST_RUN, ST_RUN);
        run_cycles(5);
        push_period(4, ST_RUN, ST_BREAK);
        run_cycles(1);
        brk = 1'b1;
        run_cycles(1);
        brk = 1'b0;
        run_cycles(2);
        repeat (4) push_e(1'b0, 1'b0, ST_BREAK);
        run_cycles(4);
        run = 1'b0;
        push_e(1'b0, 1'b0, ST_HALT);
        run_cycles(1);
        run = 1'b1;
        push_e(1'b0, 1'b0, ST_RUN);
        push_period(4, ST_RUN, ST_RUN);
        run_cycles(5);

        // Counter wrap: preload the last value before a pulse
        phase = "wrap";
        force dut.r_cyc_cnt = 16'hFFFF;
        #1;
        release dut.r_cyc_cnt;
        exp_cyc = 16'hFFFF;
        push_e(1'b1, 1'b1, ST_RUN);
        push_e(1'b1, 1'b0, ST_RUN);
        run_cycles(2);

        // Asynchronous reset during the high phase
        phase = "async_rst";
        rst = 1'b1;
        #1;
        check("clk_cpu", {31'd0, Clk_CPU}, 32'd0);
        check("cpu_en",  {31'd0, cpu_en}, 32'd0);
        check("state",   {30'd0, state}, {30'd0, ST_HALT});
        check("cyc_cnt", {16'd0, cyc_cnt}, 32'd0);
        run = 1'b0;
        exp_cyc = 16'd0;
        repeat (2) push_e(1'b0, 1'b0, ST_HALT);
        run_cycles(2);
        rst = 1'b0;
        repeat (3) push_e(1'b0, 1'b0, ST_HALT);
        run_cycles(3);

        phase = "end";
        check("sb_leftover", 32'(sb_q.size()), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
